// File: rtl/sdm_sample_sched_pkg.sv
// Shared types and constants for the sigma-delta sample scheduler.
package sdm_sample_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } sched_state_e;

   localparam int unsigned RAMP_SHIFT_DEFAULT = 4;
   localparam int unsigned GAIN_MAX           = 2 ** RAMP_SHIFT_DEFAULT;

   function automatic int unsigned midscale(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/sdm_sample_fifo.sv
// Small synchronous sample FIFO with registered occupancy and flags.
module sdm_sample_fifo #(
   parameter int unsigned W     = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_data,
   output logic [W-1:0]               o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [LW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == LW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_level = r_count;
   assign o_data  = r_mem[r_rd];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/sdm_sample_sched.sv
// Sample scheduler and soft-mute ramp feeding the sigma-delta modulator din.
module sdm_sample_sched
   import sdm_sample_sched_pkg::*;
#(
   parameter int unsigned W          = 12,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_W      = 10,
   parameter int unsigned RAMP_SHIFT = RAMP_SHIFT_DEFAULT
) (
   input  logic                          clk_fast,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [DIV_W-1:0]              div,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [W-1:0]                  s_data,
   output logic [W-1:0]                  sdm_din,
   output logic                          sample_tick,
   output logic                          underrun,
   output logic [1:0]                    state,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned GW = RAMP_SHIFT + 1;
   localparam int unsigned PW = W + RAMP_SHIFT + 2;
   localparam logic [W-1:0]  MID   = W'(midscale(W));
   localparam logic [GW-1:0] G_MAX = GW'(2 ** RAMP_SHIFT);
   localparam logic [LW-1:0] HALF  = LW'(FIFO_DEPTH / 2);

   sched_state_e     r_state;
   sched_state_e     w_nstate;
   logic [GW-1:0]    r_g;
   logic [GW-1:0]    w_ng;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_cur;
   logic             w_tick;
   logic [W-1:0]     r_last;
   logic [W-1:0]     r_sdm;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [LW-1:0]    w_level;
   logic [W-1:0]     w_fifo_data;
   logic [W:0]       w_diff;
   logic [PW-1:0]    w_diff_ext;
   logic [PW-1:0]    w_g_ext;
   logic [PW-1:0]    w_prod;
   logic [W-1:0]     w_out;
   logic             w_unused_prod;

   sdm_sample_fifo #(
      .W     (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk_fast),
      .i_rst_n (rst_n),
      .i_push  (s_valid),
      .i_pop   (w_pop),
      .i_data  (s_data),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // div is taken live in the first cycle of a period and held until the next wrap
   assign w_div_cur   = (r_cnt == '0) ? div : r_div;
   assign w_tick      = (r_cnt == w_div_cur);
   assign sample_tick = w_tick;

   assign w_pop      = w_tick & (r_state != IDLE) & ~w_empty;
   assign underrun   = w_tick & (r_state == RUN) & w_empty;
   assign s_ready    = ~w_full;
   assign fifo_level = w_level;
   assign state      = r_state;
   assign sdm_din    = r_sdm;

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_div <= '0;
      end else begin
         if (r_cnt == '0) r_div <= div;
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_ng     = r_g;
      unique case (r_state)
         IDLE: begin
            if (enable && (w_level >= HALF)) w_nstate = RAMP_UP;
         end
         RAMP_UP: begin
            if (!enable) begin
               w_nstate = RAMP_DOWN;
            end else if (w_tick) begin
               if (r_g >= G_MAX) begin
                  w_nstate = RUN;
               end else begin
                  w_ng = r_g + 1'b1;
                  if (r_g == G_MAX - 1'b1) w_nstate = RUN;
               end
            end
         end
         RUN: begin
            if (!enable) begin
               w_nstate = RAMP_DOWN;
               w_ng     = G_MAX;
            end
         end
         RAMP_DOWN: begin
            if (enable) begin
               w_nstate = RAMP_UP;
            end else if (w_tick) begin
               if (r_g == '0) begin
                  w_nstate = IDLE;
               end else begin
                  w_ng = r_g - 1'b1;
                  if (r_g == GW'(1)) w_nstate = IDLE;
               end
            end
         end
      endcase
   end

   // Signed offset from midscale scaled by g / 2^RAMP_SHIFT
   assign w_diff        = {1'b0, r_last} - {1'b0, MID};
   assign w_diff_ext    = {{(PW - W - 1){w_diff[W]}}, w_diff};
   assign w_g_ext       = {{(PW - GW){1'b0}}, r_g};
   assign w_prod        = $signed(w_diff_ext) * $signed(w_g_ext);
   assign w_out         = MID + w_prod[RAMP_SHIFT +: W];
   assign w_unused_prod = ^{w_prod[PW-1:RAMP_SHIFT+W], w_prod[RAMP_SHIFT-1:0]};

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_g     <= '0;
         r_last  <= MID;
         r_sdm   <= MID;
      end else begin
         r_state <= w_nstate;
         r_g     <= w_ng;
         if (w_pop) r_last <= w_fifo_data;
         r_sdm   <= (r_state == IDLE) ? MID : w_out;
      end
   end

endmodule

// File: tb/tb_sdm_sample_sched.sv
// Scoreboard bench for sdm_sample_sched against a queue-based reference model.
module tb_sdm_sample_sched;

   localparam int W   = 12;
   localparam int D   = 4;
   localparam int DW  = 10;
   localparam int RS  = 2;
   localparam int MID = 2048;
   localparam int GM  = 4;

   localparam int M_IDLE = 0;
   localparam int M_UP   = 1;
   localparam int M_RUN  = 2;
   localparam int M_DOWN = 3;

   logic          clk_fast = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [DW-1:0] div;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic [W-1:0]  sdm_din;
   logic          sample_tick;
   logic          underrun;
   logic [1:0]    state;
   logic [2:0]    fifo_level;

   always #5 clk_fast = ~clk_fast;

   sdm_sample_sched #(
      .W          (W),
      .FIFO_DEPTH (D),
      .DIV_W      (DW),
      .RAMP_SHIFT (RS)
   ) dut (
      .clk_fast    (clk_fast),
      .rst_n       (rst_n),
      .enable      (enable),
      .div         (div),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .sdm_din     (sdm_din),
      .sample_tick (sample_tick),
      .underrun    (underrun),
      .state       (state),
      .fifo_level  (fifo_level)
   );

   typedef struct {
      int sdm;
      int st;
      int lvl;
      int rdy;
      int tick;
      int und;
   } exp_t;

   exp_t sb[$];

   // reference model: sample queue, gain, phase within the period
   int  m_q[$];
   int  m_phase, m_period, m_mode, m_g, m_last, m_sdm;
   bit  m_acc;
   int  n_vec = 0;
   int  n_err = 0;
   bit  done  = 1'b0;

   function automatic int floor_div(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_period = 0;
      m_mode   = M_IDLE;
      m_g      = 0;
      m_last   = MID;
      m_sdm    = MID;
      m_acc    = 1'b0;
      m_q.delete();
   endtask

   function automatic exp_t model_outputs(output bit tick);
      exp_t e;
      int   len;
      len    = (m_phase == 0) ? int'(div) : m_period;
      tick   = (m_phase == len);
      e.sdm  = m_sdm;
      e.st   = m_mode;
      e.lvl  = m_q.size();
      e.rdy  = (m_q.size() < D) ? 1 : 0;
      e.tick = tick ? 1 : 0;
      e.und  = (tick && m_mode == M_RUN && m_q.size() == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic step();
      exp_t e;
      bit   tick, push, pop;
      int   lvl, nsdm;
      e = model_outputs(tick);
      sb.push_back(e);
      lvl  = m_q.size();
      push = s_valid && (lvl < D);
      pop  = tick && (m_mode != M_IDLE) && (lvl > 0);
      nsdm = (m_mode == M_IDLE) ? MID : MID + floor_div((m_last - MID) * m_g, GM);
      if (pop)  m_last = m_q.pop_front();
      if (push) m_q.push_back(int'(s_data));
      m_acc = push;
      case (m_mode)
         M_IDLE: if (enable && lvl >= D / 2) m_mode = M_UP;
         M_UP: begin
            if (!enable) m_mode = M_DOWN;
            else if (tick) begin
               if (m_g < GM) m_g = m_g + 1;
               if (m_g == GM) m_mode = M_RUN;
            end
         end
         M_RUN: if (!enable) begin m_mode = M_DOWN; m_g = GM; end
         default: begin
            if (enable) m_mode = M_UP;
            else if (tick) begin
               if (m_g > 0) m_g = m_g - 1;
               if (m_g == 0) m_mode = M_IDLE;
            end
         end
      endcase
      m_sdm = nsdm;
      if (m_phase == 0) m_period = int'(div);
      m_phase = tick ? 0 : m_phase + 1;
      @(negedge clk_fast);
   endtask

   // asynchronous reset asserted mid-cycle; outputs must already be at reset values
   task automatic reset_cycle();
      exp_t e;
      bit   tick;
      s_valid = 1'b0;
      model_reset();
      e = model_outputs(tick);
      sb.push_back(e);
      #2 rst_n = 1'b0;
      @(negedge clk_fast);
   endtask

   task automatic drive(input int vrate, input int fixed);
      if (!(s_valid && !m_acc)) begin
         s_valid = ($urandom_range(99) < vrate);
         s_data  = (fixed >= 0) ? W'(fixed) : W'($urandom_range(4095));
      end
      step();
   endtask

   task automatic chk(input string name, input int got, input int want);
      if (got !== want) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_fast);
         #4;
         if (done) break;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries, required 1", $time);
         end else begin
            e = sb.pop_front();
            n_vec++;
            chk("sdm_din",     int'(sdm_din),     e.sdm);
            chk("state",       int'(state),       e.st);
            chk("fifo_level",  int'(fifo_level),  e.lvl);
            chk("s_ready",     int'(s_ready),     e.rdy);
            chk("sample_tick", int'(sample_tick), e.tick);
            chk("underrun",    int'(underrun),    e.und);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no completion, required finish within budget");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst_n   = 1'b0;
      enable  = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      div     = DW'(3);
      model_reset();
      @(negedge clk_fast);
      repeat (3) reset_cycle();
      rst_n = 1'b1;

      repeat (16) drive(0, -1);

      enable = 1'b1;
      repeat (40) drive(100, 'hC00);

      repeat (40) drive(0, -1);
      repeat (20) drive(100, 'hC00);

      enable = 1'b0;
      repeat (30) drive(100, 'hC00);

      enable = 1'b1;
      repeat (40) drive(100, 'hC00);
      enable = 1'b0;
      repeat (9) drive(100, 'hC00);
      enable = 1'b1;
      repeat (30) drive(100, 'hC00);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(39) == 0) enable = ~enable;
         if ($urandom_range(149) == 0) div = DW'($urandom_range(5));
         drive(60, -1);
      end

      enable = 1'b0;
      div    = DW'(3);
      repeat (60) drive(0, -1);
      reset_cycle();
      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (3) drive(100, -1);
      for (int i = 0; i < 8 && m_mode != M_UP; i++) drive(0, -1);
      drive(0, -1);
      reset_cycle();
      div   = '0;
      rst_n = 1'b1;
      enable = 1'b0;
      repeat (20) drive(50, -1);
      enable = 1'b1;
      repeat (60) drive(70, -1);

      done = 1'b1;
      #20;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
